pipeline_seq_ctrl: RTL and testbench
====================================

Name: pipeline_seq_ctrl

Overview:
- Sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It sits beside the main opcode decoder.
- Generates the PC-write, IF/ID-write and flush controls for three cases: load-use stalls, taken-branch flushes, and the HLT drain sequence.
- Holds the pipeline halted until an external resume pulse arrives.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- DRAIN_CYCLES, 3, bubble cycles after HLT reaches ID before halted asserts (retires EX/MEM/WB); legal 1..15.
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_opcode  in  7  opcode of the instruction in ID.
- id_rs1  in  5  rs1 field in ID.
- id_rs2  in  5  rs2 field in ID.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch in EX resolved taken; PC redirect is applied this cycle.
- resume  in  1  single-cycle pulse; leaves the HALTED state.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID register loads a NOP.
- idex_flush  out  1  ID/EX register loads a bubble (all control bits 0).
- halted  out  1  registered; 1 while in HALTED.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  taken-branch flush cycles, saturating.

Behaviour:
- States: RUN, DRAIN, HALTED.
- Reset (asynchronous, any time including mid-DRAIN):
  - state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, halted=0.
  - Combinational outputs take their RUN values.
- Control outputs are combinational from the state and the inputs in the same cycle. halted, the counters and the state are registered.
- uses_rs1 = opcode in {R_TYPE, I_TYPE, LW, SW, BR}. uses_rs2 = opcode in {R_TYPE, SW, BR}.
- load_use = ex_memread && ex_rd!=0 && ((uses_rs1 && ex_rd==id_rs1) || (uses_rs2 && ex_rd==id_rs2)).
- RUN, evaluated in priority order:
  1. ex_branch_taken:
     - pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1.
     - flush_cnt+1.
     - Overrides load_use and HLT, since both are on the wrong path. Stay RUN.
  2. load_use:
     - pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0.
     - stall_cnt+1. Stay RUN.
  3. id_opcode==HLT (7'b1111111):
     - pc_write=0, ifid_write=0, idex_flush=1.
     - drain counter <= DRAIN_CYCLES-1. Next state DRAIN.
  4. Otherwise: pc_write=1, ifid_write=1, both flushes=0.
- DRAIN:
  - pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0.
  - ex_branch_taken, load_use and resume are ignored.
  - Counter decrements; when counter==0, next state HALTED.
  - halted rises exactly DRAIN_CYCLES+1 clock edges after HLT is first seen in ID.
- HALTED:
  - With resume=0: pc_write=0, ifid_write=0, idex_flush=1; HLT stays held in IF/ID.
  - With resume=1: pc_write=1, ifid_write=1 (HLT replaced by HLT+4), idex_flush=1 (HLT never enters EX). Next state RUN; halted falls on the next edge.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Shared package (riscv_pkg) holds:
  - Opcode constants R_TYPE, I_TYPE, LW, SW, BR, HLT, shared with the main decoder.
  - seq_state_t enum {RUN, DRAIN, HALTED}.
- One sub-module, hazard_detect (purely combinational): computes load_use from id_opcode, id_rs1/rs2, ex_memread and ex_rd.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_opcode=R_TYPE, id_rs2=5 -> pc_write=0, ifid_write=0, idex_flush=1 for one cycle; stall_cnt=1.
- No false hazard:
  - ex_rd=0 with id_rs1=0 -> no stall.
  - id_opcode=I_TYPE with id_rs2=ex_rd=7 -> no stall (I-type ignores rs2).
- Branch priority: ex_branch_taken=1 together with load_use=1 and id_opcode=HLT -> ifid_flush=1, idex_flush=1, pc_write=1; state stays RUN; flush_cnt=1, stall_cnt=0.
- Halt drain with DRAIN_CYCLES=3:
  - id_opcode=HLT -> DRAIN for 3 cycles with pc_write=0 throughout.
  - halted=1 on the 4th edge; it stays 1 for 10 idle cycles.
- Resume: pulse resume in HALTED -> same cycle pc_write=1, ifid_write=1, idex_flush=1; next edge halted=0, state RUN.
- Reset mid-DRAIN and saturation:
  - reset_n low during DRAIN -> immediately halted=0, state RUN, counters 0.
  - Force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and sequencer state type.
// Imported by the sequencer, hazard unit and main decoder.
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] HLT    = 7'b1111111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  function automatic logic uses_rs1(
    input logic [6:0] op
  );
    return op inside {R_TYPE, I_TYPE, LW, SW, BR};
  endfunction

  function automatic logic uses_rs2(
    input logic [6:0] op
  );
    return op inside {R_TYPE, SW, BR};
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports: id_opcode/id_rs1/id_rs2 from ID, ex_memread/ex_rd from EX; load_use out.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic hit_rs1;
  logic hit_rs2;

  always_comb begin
    hit_rs1  = uses_rs1(id_opcode) && (ex_rd == id_rs1);
    hit_rs2  = uses_rs2(id_opcode) && (ex_rd == id_rs2);
    // x0 is never a real producer, so a load to x0 cannot stall
    load_use = ex_memread && (ex_rd != 5'd0)
               && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/pipeline_seq_ctrl.sv
// Pipeline sequencing: load-use stall, branch flush, HLT drain/halt/resume.
// Ports: decode/EX hazard inputs, resume in; PC/IFID enables, flushes, halted, counters out.
module pipeline_seq_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             resume,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             halted_q, halted_d;
  logic             load_use;

  hazard_detect u_hazard (
    .id_opcode  (id_opcode),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        // a taken branch makes the stall/HLT in ID wrong-path
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_d    = sat_inc(flush_q);
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_d    = sat_inc(stall_q);
        end else if (id_opcode == HLT) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          drain_d    = DRAIN_INIT;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        if (drain_q == 4'd0) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      HALTED: begin
        // resume steps past HLT while still
        // keeping it out of EX
        pc_write   = resume;
        ifid_write = resume;
        idex_flush = 1'b1;
        if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        drain_d = 4'd0;
      end
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      drain_q  <= 4'd0;
      stall_q  <= '0;
      flush_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Self-checking bench for pipeline_seq_ctrl.
// Behavioural model plus directed literal checks and random stimulus.
module tb_pipeline_seq_ctrl;

  localparam int DRAIN = 3;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_H = 7'b1111111;
  localparam logic [6:0] OP_J = 7'b1101111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  id_opcode = OP_I;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_branch_taken = 1'b0;
  logic        resume = 1'b0;
  logic        pc_write, ifid_write;
  logic        ifid_flush, idex_flush;
  logic        halted;
  logic [15:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  // model state
  bit m_halted = 1'b0;
  int m_wait = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_seq_ctrl #(
    .DRAIN_CYCLES (DRAIN),
    .CNT_W        (16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .resume          (resume),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic bit m_load_use();
    bit r1, r2;
    r1 = (id_opcode == OP_R) || (id_opcode == OP_I)
      || (id_opcode == OP_L) || (id_opcode == OP_S)
      || (id_opcode == OP_B);
    r2 = (id_opcode == OP_R) || (id_opcode == OP_S)
      || (id_opcode == OP_B);
    if (!ex_memread || ex_rd == 0) return 1'b0;
    return (r1 && ex_rd == id_rs1)
        || (r2 && ex_rd == id_rs2);
  endfunction

  // expected {pc_write, ifid_write, ifid_flush, idex_flush}
  function automatic logic [3:0] m_ctl();
    if (m_halted) return {resume, resume, 2'b01};
    if (m_wait > 0) return 4'b0001;
    if (ex_branch_taken) return 4'b1111;
    if (m_load_use()) return 4'b0001;
    if (id_opcode == OP_H) return 4'b0001;
    return 4'b1100;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_halted = 1'b0;
      m_wait   = 0;
      m_stall  = 0;
      m_flush  = 0;
    end else if (m_halted) begin
      if (resume) m_halted = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_halted = 1'b1;
    end else if (ex_branch_taken) begin
      if (m_flush < 65535) m_flush++;
    end else if (m_load_use()) begin
      if (m_stall < 65535) m_stall++;
    end else if (id_opcode == OP_H) begin
      m_wait = DRAIN;
    end
  end

  always @(negedge clk) begin
    if (reset_n && run_cmp) begin
      logic [3:0] e;
      e = m_ctl();
      chk("m_pc_write", 32'(pc_write), 32'(e[3]));
      chk("m_ifid_write", 32'(ifid_write), 32'(e[2]));
      chk("m_ifid_flush", 32'(ifid_flush), 32'(e[1]));
      chk("m_idex_flush", 32'(idex_flush), 32'(e[0]));
      chk("m_halted", 32'(halted), 32'(m_halted));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("m_flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(
    input logic [6:0] op,
    input logic [4:0] r1,
    input logic [4:0] r2,
    input logic       mr,
    input logic [4:0] rd,
    input logic       br,
    input logic       rs
  );
    id_opcode       = op;
    id_rs1          = r1;
    id_rs2          = r2;
    ex_memread      = mr;
    ex_rd           = rd;
    ex_branch_taken = br;
    resume          = rs;
  endtask

  task automatic nop();
    set_in(OP_I, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic rand_in();
    logic [6:0] ops [7];
    logic [6:0] op;
    ops = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_H, OP_J};
    op = ops[$urandom_range(6, 0)];
    if (op == OP_H && $urandom_range(3, 0) != 0) op = OP_R;
    set_in(op,
           5'($urandom_range(3, 0)),
           5'($urandom_range(3, 0)),
           1'($urandom_range(1, 0)),
           5'($urandom_range(3, 0)),
           $urandom_range(5, 0) == 0,
           $urandom_range(7, 0) == 0);
  endtask

  initial begin
    nop();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_cmp = 1'b1;
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    step();

    // load-use on rs2 of R-type
    set_in(OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_ifid_write", 32'(ifid_write), 32'd0);
    chk("lu_idex_flush", 32'(idex_flush), 32'd1);
    step();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // no false hazards
    set_in(OP_R, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("x0_pc_write", 32'(pc_write), 32'd1);
    step();
    set_in(OP_I, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk("itype_pc_write", 32'(pc_write), 32'd1);
    chk("itype_idex_flush", 32'(idex_flush), 32'd0);
    step();
    chk("nofalse_stall", 32'(stall_cnt), 32'd1);

    // branch beats load-use, then beats HLT
    set_in(OP_R, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk("br_pc_write", 32'(pc_write), 32'd1);
    chk("br_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("br_idex_flush", 32'(idex_flush), 32'd1);
    step();
    set_in(OP_H, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk("brh_pc_write", 32'(pc_write), 32'd1);
    chk("brh_ifid_flush", 32'(ifid_flush), 32'd1);
    step();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd2);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
    nop();
    @(negedge clk);
    chk("br_still_run", 32'(pc_write), 32'd1);
    step();

    // HLT drain
    set_in(OP_H, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("hlt_pc_write", 32'(pc_write), 32'd0);
    step();
    for (int i = 0; i < DRAIN; i++) begin
      set_in(OP_R, 5'd5, 5'd5, 1'b1, 5'd5,
             1'(i == 1), 1'(i == 2));
      @(negedge clk);
      chk("drain_pc_write", 32'(pc_write), 32'd0);
      chk("drain_halted", 32'(halted), 32'd0);
      step();
    end
    chk("halt_edge", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      set_in(OP_H, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("hold_halted", 32'(halted), 32'd1);
      chk("hold_pc_write", 32'(pc_write), 32'd0);
      step();
    end

    // resume
    set_in(OP_H, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("res_pc_write", 32'(pc_write), 32'd1);
    chk("res_ifid_write", 32'(ifid_write), 32'd1);
    chk("res_idex_flush", 32'(idex_flush), 32'd1);
    step();
    nop();
    chk("res_halted", 32'(halted), 32'd0);
    @(negedge clk);
    chk("res_run", 32'(pc_write), 32'd1);
    step();

    // reset in the middle of DRAIN
    set_in(OP_H, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    nop();
    step();
    reset_n = 1'b0;
    #1;
    chk("mrst_halted", 32'(halted), 32'd0);
    chk("mrst_stall", 32'(stall_cnt), 32'd0);
    chk("mrst_flush", 32'(flush_cnt), 32'd0);
    chk("mrst_pc_write", 32'(pc_write), 32'd1);
    chk("mrst_idex_flush", 32'(idex_flush), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      step();
    end

    // saturation
    nop();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    set_in(OP_R, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    repeat (70000) step();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
    nop();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
